// File: rtl/channel_window_averager_pkg.sv
// ch_avg_pkg: geometry and types shared by the window buffer and the channel averager.
package ch_avg_pkg;
    localparam int NUM_CHANNELS = 14;
    localparam int NUM_SAMPLES  = 10;
    localparam int SAMPLE_W     = 8;
    localparam int CH_W         = 4;
    localparam int IDX_W        = 4;
    localparam int SUM_W        = 12;

    typedef logic [SUM_W-1:0]    sum_t;
    typedef logic [SAMPLE_W-1:0] sample_t;
    typedef logic [CH_W-1:0]     ch_t;
    typedef logic [IDX_W-1:0]    idx_t;

    typedef enum logic [2:0] {IDLE, READ, DIV, OUT, FIN} state_t;

    localparam ch_t  LAST_CH  = CH_W'(NUM_CHANNELS - 1);
    localparam idx_t LAST_IDX = IDX_W'(NUM_SAMPLES - 1);
    localparam idx_t END_IDX  = IDX_W'(NUM_SAMPLES);
endpackage

// File: rtl/channel_window_averager_if.sv
// channel_window_averager_if: window-buffer read port plus valid/ready result stream.
interface channel_window_averager_if;
    import ch_avg_pkg::*;
    logic    buf_rd_en;
    ch_t     buf_rd_ch;
    idx_t    buf_rd_idx;
    sample_t buf_rd_data;
    logic    out_valid;
    logic    out_ready;
    ch_t     out_ch;
    sample_t out_avg;

    modport master (
        output buf_rd_en, buf_rd_ch, buf_rd_idx, out_valid, out_ch, out_avg,
        input  buf_rd_data, out_ready
    );
    modport slave (
        input  buf_rd_en, buf_rd_ch, buf_rd_idx, out_valid, out_ch, out_avg,
        output buf_rd_data, out_ready
    );
endinterface

// File: rtl/channel_window_averager_seq_const_divider.sv
// seq_const_divider: fixed-latency restoring divide by a constant, one quotient bit per cycle.
module seq_const_divider
    import ch_avg_pkg::*;
#(
    parameter int W       = SUM_W,
    parameter int DIVISOR = NUM_SAMPLES,
    parameter int QW      = SAMPLE_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_start,
    input  logic [W-1:0]  i_dividend,
    output logic [QW-1:0] o_quotient,
    output logic          o_done
);
    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  r_rem;
    logic [W-1:0]  r_quo;
    logic [CW-1:0] r_cnt;
    logic [W:0]    w_trial;
    logic          w_ge;

    assign w_trial    = {r_rem, r_quo[W-1]};
    assign w_ge       = w_trial >= (W+1)'(DIVISOR);
    assign o_quotient = r_quo[QW-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_cnt  <= '0;
            o_done <= 1'b0;
        end else if (i_start) begin
            r_rem  <= '0;
            r_quo  <= i_dividend;
            r_cnt  <= CW'(W);
            o_done <= 1'b0;
        end else if (r_cnt != '0) begin
            r_rem  <= W'(w_ge ? w_trial - (W+1)'(DIVISOR) : w_trial);
            r_quo  <= {r_quo[W-2:0], w_ge};
            r_cnt  <= r_cnt - CW'(1);
            o_done <= r_cnt == CW'(1);
        end else begin
            o_done <= 1'b0;
        end
    end
endmodule

// File: rtl/channel_window_averager.sv
// channel_window_averager: per frame, reads each channel's window, averages it, streams (ch, avg).
// Define CH_AVG_ROUND_NEAREST_EN for round-half-up averages instead of truncation.
module channel_window_averager
    import ch_avg_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    channel_window_averager_if.master   bus,
    output logic                        busy,
    output logic                        done,
    output logic                        overrun
);
    state_t  r_state;
    ch_t     r_ch;
    idx_t    r_k;
    sum_t    r_acc;
    sum_t    w_dividend;
    sample_t w_quo;
    logic    w_div_start;
    logic    w_div_done;
    logic    w_more;

    // The last sample arrives on the final READ cycle, so it is summed straight into the divider load.
    assign w_div_start = (r_state == READ) && (r_k == END_IDX);
    assign w_more      = r_k < LAST_IDX;
    assign busy        = r_state != IDLE;
`ifdef CH_AVG_ROUND_NEAREST_EN
    assign w_dividend  = r_acc + sum_t'(bus.buf_rd_data) + sum_t'(NUM_SAMPLES / 2);
`else
    assign w_dividend  = r_acc + sum_t'(bus.buf_rd_data);
`endif

    seq_const_divider #(.W(SUM_W), .DIVISOR(NUM_SAMPLES), .QW(SAMPLE_W)) u_div (
        .clk        (clk),
        .reset      (reset),
        .i_start    (w_div_start),
        .i_dividend (w_dividend),
        .o_quotient (w_quo),
        .o_done     (w_div_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_ch           <= '0;
            r_k            <= '0;
            r_acc          <= '0;
            bus.buf_rd_en  <= 1'b0;
            bus.buf_rd_ch  <= '0;
            bus.buf_rd_idx <= '0;
            bus.out_valid  <= 1'b0;
            bus.out_ch     <= '0;
            bus.out_avg    <= '0;
            done           <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            if (start && r_state != IDLE)
                overrun <= 1'b1;
            case (r_state)
                IDLE: if (start) begin
                    r_state        <= READ;
                    r_ch           <= '0;
                    r_k            <= '0;
                    r_acc          <= '0;
                    bus.buf_rd_en  <= 1'b1;
                    bus.buf_rd_ch  <= '0;
                    bus.buf_rd_idx <= '0;
                end
                READ: begin
                    r_k            <= r_k + idx_t'(1);
                    bus.buf_rd_en  <= w_more;
                    bus.buf_rd_ch  <= w_more ? r_ch : '0;
                    bus.buf_rd_idx <= w_more ? r_k + idx_t'(1) : '0;
                    if (r_k != '0)
                        r_acc <= r_acc + sum_t'(bus.buf_rd_data);
                    if (r_k == END_IDX)
                        r_state <= DIV;
                end
                DIV: if (w_div_done) begin
                    r_state       <= OUT;
                    bus.out_valid <= 1'b1;
                    bus.out_ch    <= r_ch;
                    bus.out_avg   <= w_quo;
                end
                OUT: if (bus.out_ready) begin
                    bus.out_valid <= 1'b0;
                    if (r_ch == LAST_CH) begin
                        r_state <= FIN;
                        done    <= 1'b1;
                    end else begin
                        r_state        <= READ;
                        r_ch           <= r_ch + ch_t'(1);
                        r_k            <= '0;
                        r_acc          <= '0;
                        bus.buf_rd_en  <= 1'b1;
                        bus.buf_rd_ch  <= r_ch + ch_t'(1);
                        bus.buf_rd_idx <= '0;
                    end
                end
                FIN: begin
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_channel_window_averager.sv
// tb_channel_window_averager: scoreboard bench with a registered window-buffer model.
module tb_channel_window_averager;
    import ch_avg_pkg::*;

    typedef struct { ch_t ch; sample_t avg; } res_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic busy, done, overrun;
    int   tests = 0, fails = 0;
    int   done_cnt = 0, rd_cnt = 0, bad_ch = 0;
    logic [7:0] rd_log[$];
    res_t exp_q[$];
    sample_t mem [NUM_CHANNELS][NUM_SAMPLES];

    channel_window_averager_if bus();

    channel_window_averager dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .bus     (bus.master),
        .busy    (busy),
        .done    (done),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.buf_rd_en)
            bus.buf_rd_data <= mem[bus.buf_rd_ch][bus.buf_rd_idx];
    end

    always @(posedge clk) begin
        if (done) done_cnt++;
        if (bus.buf_rd_en) begin
            rd_cnt++;
            rd_log.push_back({bus.buf_rd_ch, bus.buf_rd_idx});
        end else if (bus.buf_rd_ch != '0) begin
            bad_ch++;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic sample_t model_avg(int c);
        int s = 0;
        for (int k = 0; k < NUM_SAMPLES; k++) s += int'(mem[c][k]);
`ifdef CH_AVG_ROUND_NEAREST_EN
        s += NUM_SAMPLES / 2;
`endif
        return sample_t'(s / NUM_SAMPLES);
    endfunction

    task automatic push_frame();
        for (int c = 0; c < NUM_CHANNELS; c++) exp_q.push_back('{ch_t'(c), model_avg(c)});
    endtask

    task automatic fill(input int val);
        for (int c = 0; c < NUM_CHANNELS; c++)
            for (int k = 0; k < NUM_SAMPLES; k++) mem[c][k] = sample_t'(val);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Consumes one frame from the scoreboard; optionally stalls a channel or injects a start mid-DIV.
    task automatic consume_frame(input int stall_ch, input int stall_len, input int ovr_ch, output int first_lat);
        int got = 0, budget = 0, stall = stall_len, ovr_cd = -1, lat = -1;
        int rd_at_stall = 0, rd_after = -1, d0 = done_cnt;
        logic stall_seen = 1'b0, unstable = 1'b0;
        ch_t hold_ch = '0;
        sample_t hold_avg = '0;
        res_t e;
        bus.out_ready = 1'b1;
        while (got < NUM_CHANNELS && budget < 2000) begin
            @(negedge clk);
            budget++;
            if (start) start = 1'b0;
            if (ovr_ch >= 0 && ovr_cd < 0 && bus.buf_rd_en && bus.buf_rd_ch == ch_t'(ovr_ch) && bus.buf_rd_idx == LAST_IDX)
                ovr_cd = 4;
            else if (ovr_cd > 0) begin
                ovr_cd--;
                if (ovr_cd == 0) start = 1'b1;
            end
            if (bus.out_valid) begin
                if (lat < 0) lat = budget;
                if (stall > 0 && bus.out_ch == ch_t'(stall_ch)) begin
                    if (!stall_seen) begin
                        stall_seen = 1'b1;
                        hold_ch = bus.out_ch;
                        hold_avg = bus.out_avg;
                        rd_at_stall = rd_cnt;
                        bus.out_ready = 1'b0;
                    end else if (bus.out_ch !== hold_ch || bus.out_avg !== hold_avg) begin
                        unstable = 1'b1;
                    end
                    stall--;
                    if (stall == 0) rd_after = rd_cnt;
                end else begin
                    bus.out_ready = 1'b1;
                    e = exp_q.size() > 0 ? exp_q.pop_front() : '{'0, '0};
                    tests++;
                    if (bus.out_ch !== e.ch || bus.out_avg !== e.avg) begin
                        fails++;
                        $display("FAIL result[%0d]: got ch=%0d avg=%0d, expected ch=%0d avg=%0d", got, bus.out_ch, bus.out_avg, e.ch, e.avg);
                    end
                    got++;
                end
            end
        end
        tests++;
        if (got !== NUM_CHANNELS) begin
            fails++;
            $display("FAIL frame_timeout: got %0d results, expected %0d", got, NUM_CHANNELS);
        end
        if (stall_len > 0) begin
            tests++;
            if (!stall_seen || unstable) begin
                fails++;
                $display("FAIL stall_hold: seen=%0b unstable=%0b, expected seen=1 unstable=0", stall_seen, unstable);
            end
            tests++;
            if (rd_after !== rd_at_stall) begin
                fails++;
                $display("FAIL stall_reads: read count %0d after stall, expected %0d", rd_after, rd_at_stall);
            end
        end
        repeat (3) @(negedge clk);
        tests++;
        if (done_cnt - d0 !== 1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL frame_done: done pulses=%0d busy=%0b, expected 1 and 0", done_cnt - d0, busy);
        end
        first_lat = lat;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({bus.buf_rd_en, bus.buf_rd_ch, bus.buf_rd_idx, bus.out_valid, bus.out_ch, bus.out_avg, busy, done, overrun} !== 25'd0) begin
            fails++;
            $display("FAIL reset_outputs: got nonzero outputs, expected all 0 (valid=%0b busy=%0b)", bus.out_valid, busy);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (busy !== 1'b0 || bus.buf_rd_en !== 1'b0) begin
            fails++;
            $display("FAIL idle_hold: busy=%0b rd_en=%0b, expected 0 0", busy, bus.buf_rd_en);
        end
    endtask

    task automatic test_constant();
        int lat;
        fill(8'h40);
        push_frame();
        pulse_start();
        consume_frame(-1, 0, -1, lat);
        tests++;
        if (lat !== 24) begin
            fail_lat: begin
                fails++;
                $display("FAIL first_latency: got %0d cycles, expected 24", lat);
            end
        end
    endtask

    task automatic test_ramp_and_reads();
        int lat, bad = 0;
        fill(0);
        for (int k = 0; k < NUM_SAMPLES; k++) mem[3][k] = sample_t'(k);
        rd_log.delete();
        bad_ch = 0;
        push_frame();
        pulse_start();
        consume_frame(-1, 0, -1, lat);
        tests++;
        if (rd_log.size() !== NUM_CHANNELS * NUM_SAMPLES) begin
            fails++;
            $display("FAIL read_count: got %0d reads, expected %0d", rd_log.size(), NUM_CHANNELS * NUM_SAMPLES);
        end else begin
            for (int i = 0; i < NUM_CHANNELS * NUM_SAMPLES; i++)
                if (rd_log[i] !== {ch_t'(i / NUM_SAMPLES), idx_t'(i % NUM_SAMPLES)}) bad++;
            if (bad != 0) begin
                fails++;
                $display("FAIL read_sequence: %0d reads out of order, expected 0", bad);
            end
        end
        tests++;
        if (bad_ch !== 0) begin
            fails++;
            $display("FAIL rd_ch_idle: %0d cycles with rd_ch nonzero while idle, expected 0", bad_ch);
        end
    endtask

    task automatic test_saturated();
        int lat;
        fill(8'hFF);
        push_frame();
        pulse_start();
        consume_frame(-1, 0, -1, lat);
    endtask

    task automatic test_backpressure();
        int lat;
        for (int c = 0; c < NUM_CHANNELS; c++)
            for (int k = 0; k < NUM_SAMPLES; k++) mem[c][k] = sample_t'($urandom_range(0, 255));
        push_frame();
        pulse_start();
        consume_frame(5, 20, -1, lat);
    endtask

    task automatic test_overrun();
        int lat;
        tests++;
        if (overrun !== 1'b0) begin
            fails++;
            $display("FAIL overrun_clear: got %0b, expected 0", overrun);
        end
        push_frame();
        pulse_start();
        consume_frame(-1, 0, 2, lat);
        tests++;
        if (overrun !== 1'b1) begin
            fails++;
            $display("FAIL overrun_set: got %0b, expected 1", overrun);
        end
        push_frame();
        pulse_start();
        consume_frame(-1, 0, -1, lat);
        tests++;
        if (overrun !== 1'b1) begin
            fails++;
            $display("FAIL overrun_sticky: got %0b, expected 1", overrun);
        end
    endtask

    task automatic test_reset_mid_frame();
        int n = 0, d0, lat;
        bus.out_ready = 1'b1;
        pulse_start();
        while (!(bus.buf_rd_en && bus.buf_rd_ch == ch_t'(7)) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= 1000) begin
            fails++;
            $display("FAIL reach_ch7: no read of channel 7 within %0d cycles", n);
        end
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if ({bus.buf_rd_en, bus.buf_rd_ch, bus.buf_rd_idx, bus.out_valid, bus.out_ch, bus.out_avg, busy, done, overrun} !== 25'd0) begin
            fails++;
            $display("FAIL mid_reset_outputs: busy=%0b overrun=%0b rd_en=%0b, expected all 0", busy, overrun, bus.buf_rd_en);
        end
        reset = 1'b0;
        d0 = done_cnt;
        repeat (30) @(negedge clk);
        tests++;
        if (done_cnt !== d0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_abort: done pulses=%0d busy=%0b, expected 0 0", done_cnt - d0, busy);
        end
        rd_log.delete();
        push_frame();
        pulse_start();
        consume_frame(-1, 0, -1, lat);
        tests++;
        if (rd_log.size() == 0 || rd_log[0] !== 8'h00) begin
            fails++;
            $display("FAIL restart_ch0: first read %0h, expected 00", rd_log.size() ? rd_log[0] : 8'hxx);
        end
    endtask

    initial begin
        bus.out_ready = 1'b0;
        test_reset();
        test_constant();
        test_ramp_and_reads();
        test_saturated();
        test_backpressure();
        test_overrun();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
